// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller: accepts one instruction, drives the external combinational ALU, writes back result/flags.
// Define ALUSEQ_SELFCHECK_EN to build the internal result checker behind chk_err.
module alu_op_sequencer #(
    parameter int unsigned ALU_WAIT = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ins_valid,
    output logic       ins_ready,
    input  logic [2:0] ins_op,
    input  logic [1:0] ins_rd,
    input  logic [1:0] ins_rs,
    input  logic [7:0] ins_imm,
    output logic       alu_m,
    output logic [3:0] alu_s,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [7:0] alu_t,
    input  logic       alu_cf,
    input  logic       alu_zf,
    output logic       done,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       flag_cf,
    output logic       flag_zf,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data,
    output logic       chk_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;
    typedef enum logic [2:0] {
        OP_LDI = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
        OP_AND = 3'd4, OP_NOT = 3'd5, OP_OUT = 3'd6, OP_NOP = 3'd7
    } op_t;

    state_t     r_state, w_next;
    op_t        r_op;
    logic [1:0] r_rd;
    logic [2:0] r_cnt;
    logic [7:0] r_regs [4];
    logic       r_alu_m;
    logic [3:0] r_alu_s;
    logic [7:0] r_alu_a, r_alu_b;
    logic       r_done, r_out_valid, r_cf, r_zf;
    logic [7:0] r_out_data;
    logic       w_m;
    logic [3:0] w_s;
    logic [7:0] w_a, w_b, w_rd_val, w_rs_val;
    logic       w_wb;

    assign w_rd_val  = r_regs[ins_rd];
    assign w_rs_val  = r_regs[ins_rs];
    assign w_wb      = (r_state == S_ISSUE) && (r_cnt == '0);
    assign ins_ready = (r_state == S_IDLE);
    assign alu_m     = r_alu_m;
    assign alu_s     = r_alu_s;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign done      = r_done;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign flag_cf   = r_cf;
    assign flag_zf   = r_zf;
    assign dbg_data  = r_regs[dbg_sel];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (ins_valid) w_next = S_ISSUE;
            S_ISSUE: if (r_cnt == '0) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // SUB puts rs on a and rd on b because the ALU computes b-a
    always_comb begin
        w_m = 1'b0;
        w_s = '0;
        w_a = '0;
        w_b = '0;
        case (op_t'(ins_op))
            OP_LDI: begin w_s = 4'b1100; w_a = ins_imm; end
            OP_MOV: begin w_s = 4'b1100; w_a = w_rs_val; end
            OP_ADD: begin w_m = 1'b1; w_s = 4'b1001; w_a = w_rd_val; w_b = w_rs_val; end
            OP_SUB: begin w_m = 1'b1; w_s = 4'b0110; w_a = w_rs_val; w_b = w_rd_val; end
            OP_AND: begin w_m = 1'b1; w_s = 4'b1011; w_a = w_rd_val; w_b = w_rs_val; end
            OP_NOT: begin w_m = 1'b1; w_s = 4'b0101; w_b = w_rs_val; end
            OP_OUT: begin w_s = 4'b1010; w_b = w_rs_val; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NOP;
            r_rd        <= '0;
            r_cnt       <= '0;
            for (int unsigned i = 0; i < 4; i++) r_regs[i] <= '0;
            r_alu_m     <= 1'b0;
            r_alu_s     <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_cf        <= 1'b0;
            r_zf        <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ins_valid) begin
                        r_op    <= op_t'(ins_op);
                        r_rd    <= ins_rd;
                        r_alu_m <= w_m;
                        r_alu_s <= w_s;
                        r_alu_a <= w_a;
                        r_alu_b <= w_b;
                        r_cnt   <= 3'(ALU_WAIT);
                    end
                end
                S_ISSUE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 3'd1;
                    end else begin
                        r_done  <= 1'b1;
                        r_alu_m <= 1'b0;
                        r_alu_s <= '0;
                        r_alu_a <= '0;
                        r_alu_b <= '0;
                        case (r_op)
                            OP_LDI, OP_MOV, OP_AND, OP_NOT: r_regs[r_rd] <= alu_t;
                            OP_ADD, OP_SUB: begin
                                r_regs[r_rd] <= alu_t;
                                r_cf         <= alu_cf;
                                r_zf         <= alu_zf;
                            end
                            OP_OUT: begin
                                r_out_data  <= alu_t;
                                r_out_valid <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ALUSEQ_SELFCHECK_EN
    logic [8:0] w_exp;
    logic       w_mismatch;
    logic       r_chk_err;

    // Expected result is rebuilt from the held ALU operands, so it reflects accept-time register values
    always_comb begin
        w_exp = '0;
        case (r_op)
            OP_LDI, OP_MOV: w_exp = {1'b0, r_alu_a};
            OP_ADD:         w_exp = {1'b0, r_alu_a} + {1'b0, r_alu_b};
            OP_SUB:         w_exp = {1'b0, r_alu_b} - {1'b0, r_alu_a};
            OP_AND:         w_exp = {1'b0, r_alu_a & r_alu_b};
            OP_NOT:         w_exp = {1'b0, ~r_alu_b};
            OP_OUT:         w_exp = {1'b0, r_alu_b};
            default:        w_exp = '0;
        endcase
        w_mismatch = 1'b0;
        if (r_op != OP_NOP) w_mismatch = (alu_t != w_exp[7:0]);
        if (r_op == OP_ADD || r_op == OP_SUB)
            w_mismatch = w_mismatch || (alu_cf != w_exp[8]) || (alu_zf != (w_exp[7:0] == '0));
    end

    always_ff @(posedge clk) begin
        if (rst)                     r_chk_err <= 1'b0;
        else if (w_wb && w_mismatch) r_chk_err <= 1'b1;
    end

    assign chk_err = r_chk_err;
`else
    assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomised self-checking bench for alu_op_sequencer with a behavioural ALU and a transaction-level reference model.
// Builds with or without ALUSEQ_SELFCHECK_EN; the checker-fault scenario runs only when it is defined.
module tb_alu_op_sequencer;
    localparam int unsigned WAIT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ins_valid = 1'b0;
    logic       ins_ready;
    logic [2:0] ins_op = '0;
    logic [1:0] ins_rd = '0;
    logic [1:0] ins_rs = '0;
    logic [7:0] ins_imm = '0;
    logic       alu_m;
    logic [3:0] alu_s;
    logic [7:0] alu_a, alu_b, alu_t;
    logic       alu_cf, alu_zf;
    logic       done, out_valid, flag_cf, flag_zf, chk_err;
    logic [7:0] out_data, dbg_data;
    logic [1:0] dbg_sel = '0;
    logic       corrupt = 1'b0;
    logic [8:0] alu_r9;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.ALU_WAIT(WAIT)) u_dut (
        .clk(clk), .rst(rst),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_op(ins_op), .ins_rd(ins_rd), .ins_rs(ins_rs), .ins_imm(ins_imm),
        .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b),
        .alu_t(alu_t), .alu_cf(alu_cf), .alu_zf(alu_zf),
        .done(done), .out_valid(out_valid), .out_data(out_data),
        .flag_cf(flag_cf), .flag_zf(flag_zf),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .chk_err(chk_err)
    );

    // External combinational ALU; corrupt flips result bit 0 to exercise the checker
    always_comb begin
        case ({alu_m, alu_s})
            5'b0_1100: alu_r9 = {1'b0, alu_a};
            5'b1_1001: alu_r9 = {1'b0, alu_a} + {1'b0, alu_b};
            5'b1_0110: alu_r9 = {1'b0, alu_b} - {1'b0, alu_a};
            5'b1_1011: alu_r9 = {1'b0, alu_a & alu_b};
            5'b1_0101: alu_r9 = {1'b0, ~alu_b};
            5'b0_1010: alu_r9 = {1'b0, alu_b};
            default:   alu_r9 = '0;
        endcase
        alu_t  = alu_r9[7:0] ^ {7'b0, corrupt};
        alu_cf = alu_r9[8];
        alu_zf = (alu_r9[7:0] == 8'h00);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural state plus the schedule of the one instruction in flight
    logic [7:0] m_r [4];
    logic       m_cf, m_zf, m_chk;
    logic [7:0] m_out;
    int         cyc = 0;
    int         acc = -1000;
    int         prev_acc = -1;
    bit         cont = 0;
    bit         armed = 0;
    bit         busy, indone;
    logic [2:0] p_op;
    logic [1:0] p_rd;
    logic       p_m, p_cf, wb_corrupt;
    logic [3:0] p_s;
    logic [7:0] p_a, p_b, p_res, va, vb, wres;
    logic [8:0] t9;

    initial begin
        forever begin
            @(negedge clk);
            busy   = (cyc >= acc) && (cyc <= acc + int'(WAIT));
            indone = (cyc == acc + int'(WAIT) + 1);
            if (armed) begin
                if (indone) begin
                    wres = p_res ^ {7'b0, wb_corrupt};
                    case (p_op)
                        3'd0, 3'd1, 3'd4, 3'd5: m_r[p_rd] = wres;
                        3'd2, 3'd3: begin
                            m_r[p_rd] = wres;
                            m_cf = p_cf;
                            m_zf = (p_res == 8'h00);
                        end
                        3'd6: m_out = wres;
                        default: ;
                    endcase
`ifdef ALUSEQ_SELFCHECK_EN
                    if (wb_corrupt && p_op != 3'd7) m_chk = 1'b1;
`endif
                end
                chk("ins_ready", 32'(ins_ready), 32'(!(busy || indone)));
                chk("alu_m",     32'(alu_m),     busy ? 32'(p_m) : 32'd0);
                chk("alu_s",     32'(alu_s),     busy ? 32'(p_s) : 32'd0);
                chk("alu_a",     32'(alu_a),     busy ? 32'(p_a) : 32'd0);
                chk("alu_b",     32'(alu_b),     busy ? 32'(p_b) : 32'd0);
                chk("done",      32'(done),      32'(indone));
                chk("out_valid", 32'(out_valid), 32'(indone && p_op == 3'd6));
                chk("out_data",  32'(out_data),  32'(m_out));
                chk("flag_cf",   32'(flag_cf),   32'(m_cf));
                chk("flag_zf",   32'(flag_zf),   32'(m_zf));
                chk("dbg_data",  32'(dbg_data),  32'(m_r[dbg_sel]));
                chk("chk_err",   32'(chk_err),   32'(m_chk));
                if (cyc == acc + int'(WAIT)) wb_corrupt = corrupt;
            end
            if (!ins_valid) cont = 0;
            if (rst) begin
                for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
                m_cf = 0; m_zf = 0; m_chk = 0; m_out = 8'h00;
                acc = -1000; prev_acc = -1; cont = 0; armed = 1;
            end else if (armed && !(busy || indone) && ins_valid) begin
                acc = cyc + 1;
                if (cont && prev_acc >= 0) chk("accept_to_accept", 32'(acc - prev_acc), 32'(3 + WAIT));
                prev_acc = acc;
                cont = 1;
                va = m_r[ins_rd];
                vb = m_r[ins_rs];
                p_op = ins_op; p_rd = ins_rd; p_cf = 1'b0;
                p_m = 1'b0; p_s = 4'b0000; p_a = 8'h00; p_b = 8'h00; p_res = 8'h00;
                case (ins_op)
                    3'd0: begin p_s = 4'b1100; p_a = ins_imm; p_res = ins_imm; end
                    3'd1: begin p_s = 4'b1100; p_a = vb; p_res = vb; end
                    3'd2: begin
                        p_m = 1; p_s = 4'b1001; p_a = va; p_b = vb;
                        t9 = {1'b0, va} + {1'b0, vb};
                        p_res = t9[7:0]; p_cf = t9[8];
                    end
                    3'd3: begin
                        p_m = 1; p_s = 4'b0110; p_a = vb; p_b = va;
                        t9 = {1'b0, va} - {1'b0, vb};
                        p_res = t9[7:0]; p_cf = t9[8];
                    end
                    3'd4: begin p_m = 1; p_s = 4'b1011; p_a = va; p_b = vb; p_res = va & vb; end
                    3'd5: begin p_m = 1; p_s = 4'b0101; p_b = vb; p_res = ~vb; end
                    3'd6: begin p_s = 4'b1010; p_b = vb; p_res = vb; end
                    default: ;
                endcase
            end
            dbg_sel = 2'($urandom_range(0, 3));
            cyc++;
        end
    end

    task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs, input logic [7:0] imm);
        bit taken;
        taken = 0;
        ins_op = op; ins_rd = rd; ins_rs = rs; ins_imm = imm;
        ins_valid = 1'b1;
        for (int k = 0; k < 50 && !taken; k++) begin
            @(negedge clk);
            if (ins_ready) begin
                @(posedge clk);
                #1;
                ins_valid = 1'b0;
                taken = 1;
            end
        end
        if (!taken) begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: ins_ready stayed 0 for 50 cycles, required 1");
            ins_valid = 1'b0;
        end
    endtask

    task automatic settle();
        repeat (WAIT + 2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        issue(3'd0, 2'd0, 2'd0, 8'hF0);
        issue(3'd0, 2'd1, 2'd0, 8'h20);
        issue(3'd2, 2'd0, 2'd1, 8'h00);
        settle();
        chk("pin_add_r0", 32'(m_r[0]), 32'h10);
        chk("pin_add_cf", 32'(flag_cf), 32'd1);
        chk("pin_add_zf", 32'(flag_zf), 32'd0);

        issue(3'd0, 2'd2, 2'd0, 8'h05);
        issue(3'd0, 2'd3, 2'd0, 8'h05);
        issue(3'd3, 2'd2, 2'd3, 8'h00);
        settle();
        chk("pin_sub0_r2", 32'(m_r[2]), 32'h00);
        chk("pin_sub0_zf", 32'(flag_zf), 32'd1);
        chk("pin_sub0_cf", 32'(flag_cf), 32'd0);
        issue(3'd0, 2'd2, 2'd0, 8'h03);
        issue(3'd3, 2'd2, 2'd3, 8'h00);
        settle();
        chk("pin_sub1_r2", 32'(m_r[2]), 32'hFE);
        chk("pin_sub1_cf", 32'(flag_cf), 32'd1);

        issue(3'd0, 2'd1, 2'd0, 8'h0F);
        issue(3'd5, 2'd0, 2'd1, 8'h00);
        settle();
        chk("pin_not_r0", 32'(m_r[0]), 32'hF0);
        issue(3'd4, 2'd0, 2'd1, 8'h00);
        settle();
        chk("pin_and_r0", 32'(m_r[0]), 32'h00);
        chk("pin_and_cf", 32'(flag_cf), 32'd1);
        chk("pin_and_zf", 32'(flag_zf), 32'd0);

        issue(3'd0, 2'd0, 2'd0, 8'hA5);
        issue(3'd6, 2'd2, 2'd0, 8'h00);
        settle();
        chk("pin_out_data", 32'(out_data), 32'hA5);

        for (int i = 0; i < 6; i++) issue(3'(i), 2'(i), 2'(i + 1), 8'(i * 37));
        settle();

        issue(3'd2, 2'd0, 2'd1, 8'h00);
        @(posedge clk);
        #1;
        pulse_rst();
        settle();
        chk("pin_rst_r0", 32'(m_r[0]), 32'h00);

`ifdef ALUSEQ_SELFCHECK_EN
        issue(3'd0, 2'd0, 2'd0, 8'h01);
        issue(3'd0, 2'd1, 2'd0, 8'h02);
        corrupt = 1'b1;
        issue(3'd2, 2'd0, 2'd1, 8'h00);
        settle();
        corrupt = 1'b0;
        chk("pin_chk_set", 32'(chk_err), 32'd1);
        issue(3'd0, 2'd2, 2'd0, 8'h09);
        settle();
        chk("pin_chk_sticky", 32'(chk_err), 32'd1);
        pulse_rst();
        @(posedge clk);
        #1;
`endif

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 4)) @(posedge clk);
            #0;
            issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom));
            if ($urandom_range(0, 19) == 0) begin
                repeat ($urandom_range(0, WAIT)) @(posedge clk);
                #1;
                pulse_rst();
            end
        end
        settle();
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, bench did not complete");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle control unit that drives the 8-bit ALU's m/s/a/b inputs and consumes its t/cf/zf outputs.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a 4x8-bit register file.
- Issues the matching ALU function code, then writes the ALU result back to the register file and to the carry/zero flag registers.
- Sits between the instruction source (front-panel or test harness) and the combinational ALU.

Parameters:
ALU_WAIT, 0, extra cycles the ALU inputs are held stable before the result is sampled (range 0..7)

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
ins_valid  in  1  instruction present
ins_ready  out  1  sequencer can accept (high only in IDLE)
ins_op  in  3  opcode
ins_rd  in  2  destination/left register index
ins_rs  in  2  source/right register index
ins_imm  in  8  immediate for LDI
alu_m  out  1  ALU mode
alu_s  out  4  ALU function select
alu_a  out  8  ALU operand a
alu_b  out  8  ALU operand b
alu_t  in  8  ALU result
alu_cf  in  1  ALU carry/borrow (bit 8 of the 9-bit sum/difference)
alu_zf  in  1  ALU zero
done  out  1  one-cycle pulse after writeback
out_valid  out  1  one-cycle pulse with out_data (OUT op)
out_data  out  8  registered OUT value
flag_cf  out  1  architectural carry flag
flag_zf  out  1  architectural zero flag
dbg_sel  in  2  register-file debug read index
dbg_data  out  8  combinational R[dbg_sel]
chk_err  out  1  sticky self-check error (see Optional Feature)

Behaviour:
- Reset (synchronous, highest priority, any state): state=IDLE; R0..R3=0; flag_cf=flag_zf=0; alu_m=0; alu_s=0000; alu_a=alu_b=0; done=out_valid=0; out_data=0; chk_err=0; wait counter=0. Reset mid-operation abandons the instruction with no writeback.
- FSM states: IDLE, ISSUE, DONE.
- IDLE: ins_ready=1. At an edge where ins_valid=1, latch the instruction, drive the ALU output registers per the opcode table, load the wait counter with ALU_WAIT, and go to ISSUE.
- ISSUE: ALU outputs held constant. If the counter is nonzero, decrement it. When the counter is 0, at that edge:
  - sample alu_t/alu_cf/alu_zf and perform the writeback;
  - return alu_m=0, alu_s=0000, alu_a=alu_b=0 to the idle code;
  - go to DONE.
- DONE: done=1 for exactly this cycle; next edge go to IDLE.
- Latency: writeback at edge 1+ALU_WAIT after accept. Accept-to-accept is 3+ALU_WAIT cycles minimum.
- Opcode table (m, s, a, b -> writeback):
  - 000 LDI: 0, 1100, a=imm, b=0 -> R[rd]=t; flags unchanged.
  - 001 MOV: 0, 1100, a=R[rs], b=0 -> R[rd]=t; flags unchanged.
  - 010 ADD: 1, 1001, a=R[rd], b=R[rs] -> R[rd]=t; flag_cf=alu_cf, flag_zf=alu_zf.
  - 011 SUB: 1, 0110, a=R[rs], b=R[rd] (ALU computes b-a, so result is R[rd]-R[rs]) -> R[rd]=t; flag_cf=alu_cf (borrow), flag_zf=alu_zf.
  - 100 AND: 1, 1011, a=R[rd], b=R[rs] -> R[rd]=t; flags unchanged.
  - 101 NOT: 1, 0101, a=0, b=R[rs] -> R[rd]=t; flags unchanged.
  - 110 OUT: 0, 1010, a=0, b=R[rs] -> out_data=t, out_valid=1 in DONE cycle; no register write.
  - 111 NOP: idle code (0, 0000) -> no write, flags unchanged; still passes through ISSUE/DONE.
- Operands are read from the register file at accept time. rd==rs is legal (e.g. ADD R1,R1 doubles R1).
- ins_valid in ISSUE/DONE is ignored (ins_ready=0); the source holds it until accepted.
- dbg_data reflects a write from the edge after writeback.

Optional Feature:
- Macro ALUSEQ_SELFCHECK_EN.
- Defined: at the writeback edge, compute the expected 8-bit result internally and compare it with alu_t. For ADD/SUB, also compute the expected 9-bit cf/zf and compare with alu_cf/alu_zf. On any mismatch set chk_err=1; it stays set until rst.
- Undefined: no checker logic; chk_err tied to 0.

Test Plan:
- Reset then LDI R0,0xF0; LDI R1,0x20; ADD R0,R1 -> R0=0x10, flag_cf=1, flag_zf=0, done pulse 1 cycle after writeback.
- LDI R2,0x05; LDI R3,0x05; SUB R2,R3 -> alu_a=0x05, alu_b=0x05, R2=0x00, flag_zf=1, flag_cf=0; then LDI R2,0x03; SUB R2,R3 -> R2=0xFE, flag_cf=1, flag_zf=0.
- With flags cf=1/zf=0 set: LDI R1,0x0F; NOT R0,R1 -> R0=0xF0; AND R0,R1 -> R0=0x00; flags remain cf=1, zf=0.
- OUT R0 after LDI R0,0xA5 -> out_valid single pulse with out_data=0xA5, alu_m=0 and alu_s=1010 during ISSUE, no register changes.
- ALU_WAIT=3: ins_valid held high continuously -> ins_ready high 1 cycle in every 6. ALU inputs constant for 4 cycles. Accept-to-accept exactly 6 cycles.
- rst asserted during ISSUE of ADD R0,R1 -> next cycle state IDLE, R0..R3=0, no done pulse; with ALUSEQ_SELFCHECK_EN, forcing alu_t wrong on ADD -> chk_err=1 and stays set until rst.
